// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - shared constants and encodings for the CCR/branch unit
package ccr_pkg;

  localparam int CCR_W  = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    BR_JZ  = 2'b00,
    BR_JN  = 2'b01,
    BR_JC  = 2'b10,
    BR_JMP = 2'b11
  } br_cond_e;

endpackage

// File: rtl/ccr_stack.sv
// rtl/ccr_stack.sv - parameterised LIFO holding saved CCR values
module ccr_stack #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] ptr;
  logic [W-1:0]     mem [DEPTH];

  assign empty = (ptr == '0);
  assign full  = (ptr == PTR_W'(DEPTH));

  // Top of stack lives one slot below the pointer.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == PTR_W'(i + 1)) dout = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr == PTR_W'(i)) mem[i] <= din;
      end
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// rtl/ccr_branch_unit.sv - condition code register, jump resolution and CCR save stack
module ccr_branch_unit
  import ccr_pkg::*;
#(
  parameter int STACK_DEPTH = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CCR_W-1:0]  alu_flag,
  input  logic [CCR_W-1:0]  flag_we,
  input  logic              set_c,
  input  logic              clr_c,
  input  logic              br_valid,
  input  logic [1:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              save,
  input  logic              restore,
  input  logic              stall,
  output logic [CCR_W-1:0]  ccr,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  logic [CCR_W-1:0] ccr_q, ccr_d, eff, nxt, stk_dout;
  logic             cond_true, take, push, pop, err_set;

  // Flags as this cycle's instruction sees them: ALU forwarding, then SETC/CLRC.
  always_comb begin
    eff = ccr_q;
    for (int i = 0; i < CCR_W; i++) begin
      if (flag_we[i]) eff[i] = alu_flag[i];
    end
    if (set_c) eff[FLAG_C] = 1'b1;
    if (clr_c) eff[FLAG_C] = 1'b0;
  end

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_e'(br_cond))
      BR_JZ:   cond_true = eff[FLAG_Z];
      BR_JN:   cond_true = eff[FLAG_N];
      BR_JC:   cond_true = eff[FLAG_C];
      BR_JMP:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    take = br_valid && cond_true;
    nxt  = eff;
    if (take && (br_cond_e'(br_cond) != BR_JMP)) nxt[br_cond] = 1'b0;
  end

  always_comb begin
    ccr_d   = nxt;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (save && restore) begin
      err_set = 1'b1;
    end else if (restore) begin
      if (!stack_empty) begin
        pop   = 1'b1;
        ccr_d = stk_dout;
      end else begin
        err_set = 1'b1;
      end
    end else if (save) begin
      if (!stack_full) push = 1'b1;
      else             err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q     <= '0;
      br_taken  <= 1'b0;
      br_pc     <= '0;
      stack_err <= 1'b0;
    end else if (stall) begin
      br_taken <= 1'b0;
    end else begin
      ccr_q    <= ccr_d;
      br_taken <= take;
      if (take) br_pc <= br_target;
      if (err_set) stack_err <= 1'b1;
    end
  end

  ccr_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (CCR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !stall),
    .pop   (pop && !stall),
    .din   (nxt),
    .dout  (stk_dout),
    .empty (stack_empty),
    .full  (stack_full)
  );

  assign ccr = ccr_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// tb/tb_ccr_branch_unit.sv - self-checking bench for ccr_branch_unit
module tb_ccr_branch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alu_flag = '0, flag_we = '0;
  logic        set_c = 1'b0, clr_c = 1'b0, br_valid = 1'b0;
  logic [1:0]  br_cond = '0;
  logic [15:0] br_target = '0;
  logic        save = 1'b0, restore = 1'b0, stall = 1'b0;
  logic [2:0]  ccr;
  logic        br_taken, stack_empty, stack_full, stack_err;
  logic [15:0] br_pc;

  int n_cmp = 0;
  int n_fail = 0;

  logic [2:0]  m_ccr;
  logic        m_taken, m_err;
  logic [15:0] m_pc;
  logic [2:0]  m_stk[$];

  ccr_branch_unit #(.STACK_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .alu_flag(alu_flag), .flag_we(flag_we),
    .set_c(set_c), .clr_c(clr_c), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .save(save), .restore(restore), .stall(stall),
    .ccr(ccr), .br_taken(br_taken), .br_pc(br_pc),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ccr = '0; m_taken = 1'b0; m_pc = '0; m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step();
    logic [2:0] eff, nxt;
    logic ct, tk;
    eff = m_ccr;
    for (int i = 0; i < 3; i++) if (flag_we[i]) eff[i] = alu_flag[i];
    if (set_c) eff[2] = 1'b1;
    if (clr_c) eff[2] = 1'b0;
    if (br_cond == 2'd3) ct = 1'b1;
    else                 ct = eff[br_cond];
    tk = br_valid && ct;
    nxt = eff;
    if (tk && br_cond != 2'd3) nxt[br_cond] = 1'b0;
    if (stall) begin
      m_taken = 1'b0;
      return;
    end
    m_taken = tk;
    if (tk) m_pc = br_target;
    m_ccr = nxt;
    if (save && restore) m_err = 1'b1;
    else if (restore) begin
      if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (save) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
      else m_err = 1'b1;
    end
  endtask

  task automatic step(input logic [2:0] we, input logic [2:0] af, input logic sc, input logic cc,
                      input logic bv, input logic [1:0] bc, input logic [15:0] tg,
                      input logic sv, input logic rs, input logic st);
    flag_we = we; alu_flag = af; set_c = sc; clr_c = cc;
    br_valid = bv; br_cond = bc; br_target = tg;
    save = sv; restore = rs; stall = st;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flag_we = '0; alu_flag = '0; set_c = 1'b0; clr_c = 1'b0; br_valid = 1'b0;
    br_cond = '0; br_target = '0; save = 1'b0; restore = 1'b0; stall = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ccr, br_taken, br_pc, stack_empty, stack_full, stack_err} !== {3'b000, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got ccr=%b tk=%b pc=%h e=%b f=%b err=%b exp 000 0 0000 1 0 0",
               ccr, br_taken, br_pc, stack_empty, stack_full, stack_err);
    end
  endtask

  task automatic test_forward_jz();
    do_reset();
    step(3'b001, 3'b001, 0, 0, 1, 2'b00, 16'h0040, 0, 0, 0);
    n_cmp++;
    if ({br_taken, br_pc, ccr} !== {1'b1, 16'h0040, 3'b000}) begin
      n_fail++;
      $display("FAIL forward_jz got tk=%b pc=%h ccr=%b exp 1 0040 000", br_taken, br_pc, ccr);
    end
  endtask

  task automatic test_jc_jmp();
    do_reset();
    step(3'b111, 3'b010, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 1, 2'b10, 16'h0055, 0, 0, 0);
    n_cmp++;
    if ({br_taken, ccr} !== {1'b0, 3'b010}) begin
      n_fail++;
      $display("FAIL jc_not_taken got tk=%b ccr=%b exp 0 010", br_taken, ccr);
    end
    step(3'b000, 3'b000, 0, 0, 1, 2'b11, 16'h1234, 0, 0, 0);
    n_cmp++;
    if ({br_taken, br_pc, ccr} !== {1'b1, 16'h1234, 3'b010}) begin
      n_fail++;
      $display("FAIL jmp_taken got tk=%b pc=%h ccr=%b exp 1 1234 010", br_taken, br_pc, ccr);
    end
  endtask

  task automatic test_setc_clrc();
    do_reset();
    step(3'b000, 3'b000, 1, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    n_cmp++;
    if (ccr !== 3'b100) begin n_fail++; $display("FAIL setc got ccr=%b exp 100", ccr); end
    step(3'b000, 3'b000, 1, 1, 0, 2'b00, 16'h0, 0, 0, 0);
    n_cmp++;
    if (ccr !== 3'b000) begin n_fail++; $display("FAIL clrc_wins got ccr=%b exp 000", ccr); end
    step(3'b000, 3'b000, 1, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 1, 2'b10, 16'h0777, 0, 0, 0);
    n_cmp++;
    if ({br_taken, br_pc, ccr} !== {1'b1, 16'h0777, 3'b000}) begin
      n_fail++;
      $display("FAIL jc_consume got tk=%b pc=%h ccr=%b exp 1 0777 000", br_taken, br_pc, ccr);
    end
  endtask

  task automatic test_save_restore();
    do_reset();
    step(3'b111, 3'b101, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0, 0);
    n_cmp++;
    if ({ccr, stack_empty} !== {3'b101, 1'b0}) begin
      n_fail++;
      $display("FAIL save got ccr=%b empty=%b exp 101 0", ccr, stack_empty);
    end
    step(3'b111, 3'b010, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 0, 1, 0);
    n_cmp++;
    if ({ccr, stack_empty, stack_err} !== {3'b101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL restore got ccr=%b empty=%b err=%b exp 101 1 0", ccr, stack_empty, stack_err);
    end
  endtask

  task automatic test_stack_errors();
    do_reset();
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0, 0);
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0, 0);
    n_cmp++;
    if ({stack_full, stack_empty, stack_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL two_saves got full=%b empty=%b err=%b exp 1 0 0", stack_full, stack_empty, stack_err);
    end
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0, 0);
    n_cmp++;
    if ({stack_full, stack_empty, stack_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL overflow got full=%b empty=%b err=%b exp 1 0 1", stack_full, stack_empty, stack_err);
    end
    do_reset();
    step(3'b111, 3'b011, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 0, 1, 0);
    n_cmp++;
    if ({ccr, stack_err} !== {3'b011, 1'b1}) begin
      n_fail++;
      $display("FAIL underflow got ccr=%b err=%b exp 011 1", ccr, stack_err);
    end
    do_reset();
    step(3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 1, 0);
    n_cmp++;
    if ({stack_err, stack_empty} !== 2'b11) begin
      n_fail++;
      $display("FAIL collision got err=%b empty=%b exp 1 1", stack_err, stack_empty);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(3'b111, 3'b001, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 1, 2'b11, 16'h0100, 0, 0, 0);
    step(3'b000, 3'b000, 0, 0, 1, 2'b00, 16'h0200, 1, 0, 1);
    n_cmp++;
    if ({br_taken, br_pc, ccr, stack_empty} !== {1'b0, 16'h0100, 3'b001, 1'b1}) begin
      n_fail++;
      $display("FAIL stall got tk=%b pc=%h ccr=%b empty=%b exp 0 0100 001 1", br_taken, br_pc, ccr, stack_empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(3'b111, 3'b110, 0, 0, 0, 2'b00, 16'h0, 1, 0, 0);
    step(3'b000, 3'b000, 0, 0, 1, 2'b11, 16'hBEEF, 0, 0, 0);
    n_cmp++;
    if (br_taken !== 1'b1) begin n_fail++; $display("FAIL pre_reset_taken got %b exp 1", br_taken); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ccr, br_taken, stack_empty} !== {3'b000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset got ccr=%b tk=%b empty=%b exp 000 0 1", ccr, br_taken, stack_empty);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [22:0] exp_v, got_v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(3'($urandom), 3'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           1'($urandom), 2'($urandom), 16'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      exp_v = {m_ccr, m_taken, m_pc, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_err};
      got_v = {ccr, br_taken, br_pc, stack_empty, stack_full, stack_err};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cycle %0d got=%h exp=%h (ccr,tk,pc,empty,full,err)", n, got_v, exp_v);
      end
      if (n == 200) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_forward_jz();
    test_jc_jmp();
    test_setc_clrc();
    test_save_restore();
    test_stack_errors();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
